// File: rtl/pcileech_com_pkg.sv
// Shared definitions for the communication-core serializer.
//   COM_MAGIC        : resync / idle pad dword understood by the far-end 32->64 packer
//   txser_state_t    : serializer FSM state encoding
//   pad_burst_len()  : maps the requested pad burst length into the legal 2..15 range
package pcileech_com_pkg;

  localparam logic [31:0] COM_MAGIC = 32'h66665555;

  // A single magic dword only shifts the far-end packer by one half; two
  // consecutive magic dwords are what it needs to realign. Bursts are
  // therefore never shorter than two dwords, and the 4-bit down-counter
  // caps them at fifteen.
  localparam int unsigned PAD_WORDS_MIN = 2;
  localparam int unsigned PAD_WORDS_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_MAG  = 2'd3
  } txser_state_t;

  function automatic logic [3:0] pad_burst_len(input int unsigned words);
    if (words < PAD_WORDS_MIN) begin
      return 4'(PAD_WORDS_MIN);
    end else if (words > PAD_WORDS_MAX) begin
      return 4'(PAD_WORDS_MAX);
    end else begin
      return 4'(words);
    end
  endfunction

endpackage

// File: rtl/pcileech_com_txser.sv
// 64-bit to 32-bit serializer toward the FT601 / Ethernet 32-bit port.
// Sends din[63:32] then din[31:0], inserts magic resync dwords on request and
// as a single pad burst per idle period, and flags data dwords that the far-end
// packer would mistake for a resync pattern.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   din/din_valid/din_ready    : 64-bit word input (din_ready is combinational)
//   dout/dout_valid/dout_ready : registered 32-bit dword output
//   resync_req          : one-cycle pulse, asks for a 2-dword magic sequence
//   pad_req             : level, port is starved and wants idle padding
//   collision           : one-cycle pulse after a MAGIC-valued data dword
//                         consumed right behind another MAGIC dword
//   tx_dw_count         : running count of consumed data dwords
module pcileech_com_txser
  import pcileech_com_pkg::*;
#(
  parameter logic [31:0] MAGIC     = COM_MAGIC,
  parameter int unsigned PAD_WORDS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  input  logic        resync_req,
  input  logic        pad_req,
  output logic        collision,
  output logic [31:0] tx_dw_count
);

  localparam logic [3:0] PAD_LEN  = pad_burst_len(PAD_WORDS);
  localparam logic [3:0] SYNC_LEN = 4'd2;

  txser_state_t state_reg, state_next;
  logic [31:0]  dout_reg, dout_next;
  logic         dout_valid_reg, dout_valid_next;
  logic [31:0]  lo_reg, lo_next;
  logic [3:0]   mag_left_reg, mag_left_next;
  logic         sync_pend_reg, sync_pend_next;
  logic         pad_done_reg, pad_done_next;
  logic         last_magic_reg, last_magic_next;
  logic         collision_reg, collision_next;
  logic [31:0]  count_reg, count_next;

  logic load;
  logic consumed;
  logic at_boundary;
  logic sync_now;
  logic data_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      lo_reg         <= '0;
      mag_left_reg   <= '0;
      sync_pend_reg  <= 1'b0;
      pad_done_reg   <= 1'b0;
      last_magic_reg <= 1'b0;
      collision_reg  <= 1'b0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      lo_reg         <= lo_next;
      mag_left_reg   <= mag_left_next;
      sync_pend_reg  <= sync_pend_next;
      pad_done_reg   <= pad_done_next;
      last_magic_reg <= last_magic_next;
      collision_reg  <= collision_next;
      count_reg      <= count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    dout_next       = dout_reg;
    dout_valid_next = dout_valid_reg;
    lo_next         = lo_reg;
    mag_left_next   = mag_left_reg;
    pad_done_next   = pad_done_reg;
    last_magic_next = last_magic_reg;
    collision_next  = 1'b0;
    count_next      = count_reg;

    load        = ~dout_valid_reg | dout_ready;
    consumed    = dout_valid_reg & dout_ready;
    data_state  = (state_reg == ST_HI) || (state_reg == ST_LO);
    at_boundary = (state_reg == ST_IDLE) || (state_reg == ST_LO) ||
                  ((state_reg == ST_MAG) && (mag_left_reg == 4'd1));

    // A request arriving in the very cycle of a decision already wins over
    // din, so it is folded in before the registered pending flag exists.
    sync_now       = sync_pend_reg | resync_req;
    sync_pend_next = sync_now;
    din_ready      = load & at_boundary & ~sync_now;

    if (load) begin
      if (state_reg == ST_HI) begin
        // Halves are never split by magic; low half follows directly.
        state_next = ST_LO;
        dout_next  = lo_reg;
      end else if ((state_reg == ST_MAG) && (mag_left_reg != 4'd1)) begin
        mag_left_next = mag_left_reg - 4'd1;
      end else if (sync_now) begin
        state_next      = ST_MAG;
        mag_left_next   = SYNC_LEN;
        dout_next       = MAGIC;
        dout_valid_next = 1'b1;
        sync_pend_next  = 1'b0;
      end else if (din_valid) begin
        state_next      = ST_HI;
        dout_next       = din[63:32];
        lo_next         = din[31:0];
        dout_valid_next = 1'b1;
        pad_done_next   = 1'b0;
      end else if (pad_req && !pad_done_reg) begin
        state_next      = ST_MAG;
        mag_left_next   = PAD_LEN;
        dout_next       = MAGIC;
        dout_valid_next = 1'b1;
        pad_done_next   = 1'b1;
      end else begin
        state_next      = ST_IDLE;
        dout_valid_next = 1'b0;
      end
    end

    if (consumed) begin
      last_magic_next = (dout_reg == MAGIC);
      if (data_state) begin
        count_next     = count_reg + 32'd1;
        collision_next = (dout_reg == MAGIC) & last_magic_reg;
      end
    end
  end

  assign dout        = dout_reg;
  assign dout_valid  = dout_valid_reg;
  assign collision   = collision_reg;
  assign tx_dw_count = count_reg;

endmodule

// File: tb/tb_pcileech_com_txser.sv
module tb_pcileech_com_txser;

  localparam logic [31:0] MAG = 32'h66665555;
  localparam int NW = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        resync_req = 1'b0;
  logic        pad_req = 1'b0;
  logic        collision;
  logic [31:0] tx_dw_count;

  pcileech_com_txser dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .resync_req (resync_req),
    .pad_req    (pad_req),
    .collision  (collision),
    .tx_dw_count(tx_dw_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: records every consumed dword, counts collision pulses and
  // checks that a stalled output holds still.
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          coll_seen = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_dout = '0;

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (stall_prev) begin
        check("stall_valid", dout_valid, 1'b1);
        check("stall_dout", dout, stall_dout);
      end
      if (dout_valid && dout_ready) got_q.push_back(dout);
      if (collision) coll_seen++;
      stall_prev = dout_valid & ~dout_ready;
      stall_dout = dout;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send(input logic [63:0] w);
    int n;
    n = 0;
    @(negedge clk);
    din = w;
    din_valid = 1'b1;
    #2;
    while (!din_ready && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("send_accept", din_ready, 1'b1);
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #2;
    check("settle_idle", dout_valid, 1'b0);
  endtask

  task automatic expect_stream(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check(tag, got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [31:0] rand_half();
    if ($urandom_range(0, 3) == 0) return MAG;
    return $urandom();
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [63:0] words[NW];
  logic [31:0] model_last;
  int          exp_coll;
  int          exp_count;
  int          idx;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_dout", dout, 32'h0);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_coll", collision, 1'b0);
    check("rst_count", tx_dw_count, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("rst_din_ready", din_ready, 1'b1);

    // T1: basic word, latency
    @(negedge clk);
    dout_ready = 1'b1;
    din = 64'h11112222_33334444;
    din_valid = 1'b1;
    #2;
    check("t1_accept", din_ready, 1'b1);
    @(negedge clk);
    din_valid = 1'b0;
    #2;
    check("t1_hi", dout, 32'h11112222);
    check("t1_hi_valid", dout_valid, 1'b1);
    @(negedge clk);
    #2;
    check("t1_lo", dout, 32'h33334444);
    @(negedge clk);
    #2;
    check("t1_count", tx_dw_count, 32'd2);
    check("t1_idle", dout_valid, 1'b0);
    got_q.delete();
    coll_seen = 0;
    exp_count = 2;

    // T4: all-magic data word collides once, after the low half
    send(64'h66665555_66665555);
    settle(20);
    exp_q = '{MAG, MAG};
    expect_stream("t4_stream");
    check("t4_coll", coll_seen, 1);
    exp_count += 2;
    check("t4_count", tx_dw_count, exp_count);
    coll_seen = 0;

    // T2: resync requested while a word sits in HI
    send(64'hAAAA0001_AAAA0002);
    resync_req = 1'b1;
    fork
      begin
        @(negedge clk);
        resync_req = 1'b0;
      end
    join_none
    send(64'hBBBB0003_BBBB0004);
    settle(20);
    exp_q = '{32'hAAAA0001, 32'hAAAA0002, MAG, MAG, 32'hBBBB0003, 32'hBBBB0004};
    expect_stream("t2_stream");
    check("t2_coll", coll_seen, 0);
    exp_count += 4;
    check("t2_count", tx_dw_count, exp_count);
    coll_seen = 0;

    // T3: one pad burst per idle period
    @(negedge clk);
    pad_req = 1'b1;
    settle(30);
    exp_q = '{MAG, MAG, MAG, MAG, MAG};
    expect_stream("t3_burst1");
    send(64'h66665555_00000001);
    settle(30);
    exp_q = '{MAG, 32'h00000001, MAG, MAG, MAG, MAG, MAG};
    expect_stream("t3_burst2");
    check("t3_coll", coll_seen, 1);
    exp_count += 2;
    check("t3_count", tx_dw_count, exp_count);
    @(negedge clk);
    pad_req = 1'b0;
    coll_seen = 0;
    model_last = MAG;

    // T5: random words, dout_ready toggling then random
    for (int i = 0; i < NW; i++) words[i] = {rand_half(), rand_half()};
    exp_coll = 0;
    for (int i = 0; i < NW; i++) begin
      exp_q.push_back(words[i][63:32]);
      exp_q.push_back(words[i][31:0]);
    end
    foreach (exp_q[i]) begin
      if (exp_q[i] == MAG && model_last == MAG) exp_coll++;
      model_last = exp_q[i];
    end
    idx = 0;
    for (int cyc = 0; cyc < 4000 && idx < NW; cyc++) begin
      @(negedge clk);
      dout_ready = (cyc < 120) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      din = words[idx];
      din_valid = ($urandom_range(0, 3) != 0);
      #2;
      if (din_valid && din_ready) idx++;
    end
    @(negedge clk);
    din_valid = 1'b0;
    dout_ready = 1'b1;
    check("t5_all_accepted", idx, NW);
    settle(20);
    expect_stream("t5_stream");
    check("t5_coll", coll_seen, exp_coll);
    exp_count += 2 * NW;
    check("t5_count", tx_dw_count, exp_count);
    coll_seen = 0;
    $display("random phase: %0d words, %0d collisions expected", NW, exp_coll);

    // T6: reset while holding a low half
    @(negedge clk);
    din = 64'hDDDD0005_DDDD0006;
    din_valid = 1'b1;
    #2;
    check("t6_accept", din_ready, 1'b1);
    @(negedge clk);
    din_valid = 1'b0;
    @(negedge clk);
    dout_ready = 1'b0;
    #2;
    check("t6_lo_held", dout, 32'hDDDD0006);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_dout", dout, 32'h0);
    check("t6_rst_valid", dout_valid, 1'b0);
    check("t6_rst_coll", collision, 1'b0);
    check("t6_rst_count", tx_dw_count, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dout_ready = 1'b1;
    settle(20);
    exp_q = '{32'hDDDD0005};
    expect_stream("t6_no_lo");
    check("t6_count", tx_dw_count, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcileech_com_txser.md
# pcileech_com_txser

Serializes 64-bit words into the 32-bit stream consumed by the communication core's 32→64 packer, the other end of that packer's framing. Sits between the command/response FIFO and the FT601/Ethernet 32-bit port, in the communication clock domain. Inserts the magic resync dword `0x66665555` on request, and when idle, and flags data that the far-end packer would misread as resync.

## Interface
Parameters:
- `MAGIC`, `32'h66665555`, resync/pad dword.
- `PAD_WORDS`, `5`, magic dwords per idle pad burst; legal range 2..15.

Ports:
- `clk`  in  1  single clock; everything is synchronous to its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  64  word to send; `din[63:32]` is transmitted first.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  combinational; `din` is accepted on cycles where `din_valid & din_ready`.
- `dout`  out  32  registered dword toward the 32-bit port.
- `dout_valid`  out  1  registered.
- `dout_ready`  in  1  port consumes `dout` on cycles where `dout_valid & dout_ready`.
- `resync_req`  in  1  single-cycle pulse; requests a 2-dword magic sync sequence.
- `pad_req`  in  1  level; the port is idle-starved, so pad bursts are wanted.
- `collision`  out  1  registered single-cycle pulse.
- `tx_dw_count`  out  32  data dwords sent (magic dwords excluded); wraps at 2^32.

## Operation
- FSM states:
  - `IDLE`: nothing held.
  - `HI`: `dout` holds `din[63:32]`.
  - `LO`: `dout` holds the latched low half.
  - `MAG`: `dout` holds `MAGIC`; a down-counter `mag_left[3:0]` counts the remaining magic dwords.
- Load opportunity is `~dout_valid | dout_ready`. State changes only on a load opportunity.
- Source priority at each load opportunity, evaluated from `IDLE` or at the end of `LO` or `MAG`:
  1. `sync_pend`: go to `MAG` with count 2, and clear `sync_pend`.
  2. `din_valid`: accept `din`, `dout <= din[63:32]`, latch `din[31:0]`, go to `HI`.
  3. `pad_req` with `pad_done=0`: go to `MAG` with count `PAD_WORDS`, and set `pad_done`.
  4. Otherwise go to `IDLE` with `dout_valid <= 0`.
- `HI` → `LO` on a load opportunity, with `dout <= low half`. No magic dword is ever inserted between the high and low halves.
- `MAG` decrements its count per consumed dword. At count 1, the next load opportunity applies the source priority.
- `din_ready` = load opportunity & state ∈ {`IDLE`, `LO`, last `MAG` dword} & `~sync_pend`.
- `resync_req` sets `sync_pend`.
  - A request that arrives during `HI` or `LO` is served after the current word completes.
  - A request that arrives during `MAG` is served after the burst.
  - Several requests issued before service merge into one sync sequence.
- `pad_done` clears when a data word is accepted. At most one pad burst is sent per idle period, so the port never floods with magic.
- `last_magic` flag records whether the last consumed dword equalled `MAGIC`; this includes both data and magic dwords.
  - `collision` pulses the cycle after a data dword equal to `MAGIC` is consumed while `last_magic=1`.
  - The data is still sent unchanged.
- `tx_dw_count` increments by one per consumed `HI` or `LO` dword.

## Timing
- Reset values:
  - `dout=0`, `dout_valid=0`, `collision=0`, `tx_dw_count=0`.
  - State `IDLE`; `sync_pend=0`, `pad_done=0`, `last_magic=0`.
  - `din_ready` is 1 combinationally once `rst_n` deasserts, provided state is `IDLE`.
- Latency: `din` accepted at cycle N gives `dout` = high half with valid at N+1. The low half is valid at N+2 if `dout_ready` stays high.
- Sustained throughput is 1 dword per cycle with no bubble between words; the next `din` is accepted in the cycle the `LO` dword is consumed.
- Backpressure: while `dout_valid & ~dout_ready`, `dout` and `dout_valid` hold stable and `din_ready=0`.
- `resync_req` and `din_valid` in the same `IDLE` cycle: `din` is not accepted that cycle, and the sync sequence goes first.
- Reset asserted mid-word drops the word. No partial half is emitted after reset.

## Structure
- A shared package `pcileech_com_pkg` holds:
  - `COM_MAGIC` (`32'h66665555`).
  - The state enum `txser_state_t`.
  - The rule `PAD_WORDS ≥ 2`: a single magic dword misaligns the far-end packer, and two consecutive magic dwords resync it.
- Single module with no sub-module. The statistics counter is inline.

## Test plan
- Reset, then `din=64'h11112222_33334444` with `dout_ready=1`: `dout` shows `11112222` at N+1 and `33334444` at N+2, and `tx_dw_count=2`.
- Back-to-back words with `dout_ready` toggling 1010…: there is no dword loss or duplication, `dout` is stable during stalls, and order is preserved.
- `resync_req` pulse while a word is in `HI`: output is `hi`, `lo`, `66665555`, `66665555`, then the next word.
- `pad_req=1` held with no data: exactly 5 `66665555` dwords, then `dout_valid=0` until new data arrives. After that data, a second idle period produces one more burst.
- `din=64'h66665555_66665555`: `collision` pulses once after the low half. After a pad burst, `din=64'h66665555_00000001` pulses `collision` after the high half.
- `rst_n` low while holding a low half: all outputs return to their reset values immediately, and no `lo` dword appears after release.
